// File: rtl/hash_msg_feeder.sv
// Feeds host message bytes from a small FIFO into the light-hash core's byte port.
// It then captures the resulting digest and hands it back to the host over valid/ready.
module hash_msg_feeder #(
  parameter int DEPTH       = 16,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  output logic             start_ready,
  output logic [7:0]       hc_m,
  output logic             hc_m_valid,
  output logic [63:0]      hc_len,
  input  logic             hc_hash_ready,
  input  logic [31:0]      hc_digest,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [31:0]      dig_out,
  output logic             err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DIG, DONE} state_t;

  state_t           state, state_next;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop;
  logic [LEN_W-1:0] remaining, remaining_next;
  logic [TW-1:0]    tmo_cnt, tmo_cnt_next;
  logic             hr_q, hr_rise;
  logic [7:0]       hc_m_next;
  logic             hc_m_valid_next;
  logic [63:0]      hc_len_next;
  logic             dig_valid_next;
  logic [31:0]      dig_out_next;
  logic             err_next;

  assign wr_ready    = (count != (AW+1)'(DEPTH));
  assign push        = wr_valid && wr_ready;
  assign start_ready = (state == IDLE);
  assign hr_rise     = hc_hash_ready && !hr_q;

  // Storage array is not reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      remaining   <= '0;
      tmo_cnt     <= '0;
      hr_q        <= 1'b0;
      hc_m        <= 8'h00;
      hc_m_valid  <= 1'b0;
      hc_len      <= 64'h0;
      dig_valid   <= 1'b0;
      dig_out     <= 32'h0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      remaining   <= remaining_next;
      tmo_cnt     <= tmo_cnt_next;
      hr_q        <= hc_hash_ready;
      hc_m        <= hc_m_next;
      hc_m_valid  <= hc_m_valid_next;
      hc_len      <= hc_len_next;
      dig_valid   <= dig_valid_next;
      dig_out     <= dig_out_next;
      err_timeout <= err_next;
    end
  end

  // hc_m_valid defaults low so every state that does not deliver a byte leaves a gap.
  always_comb begin
    state_next      = state;
    remaining_next  = remaining;
    tmo_cnt_next    = tmo_cnt;
    hc_m_next       = hc_m;
    hc_m_valid_next = 1'b0;
    hc_len_next     = hc_len;
    dig_valid_next  = dig_valid;
    dig_out_next    = dig_out;
    err_next        = err_timeout;
    pop             = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          hc_len_next    = 64'(msg_len);
          remaining_next = msg_len;
          err_next       = 1'b0;
          tmo_cnt_next   = '0;
          if (msg_len == '0) begin
            // Empty message: one dummy zero byte lets the core finalise.
            hc_m_valid_next = 1'b1;
            hc_m_next       = 8'h00;
            state_next      = WAIT_DIG;
          end else begin
            state_next = SEND;
          end
        end
      end
      SEND: begin
        if (count != '0) begin
          pop             = 1'b1;
          hc_m_next       = mem[rd_ptr];
          hc_m_valid_next = 1'b1;
          remaining_next  = remaining - 1'b1;
          if (remaining == LEN_W'(1)) begin
            tmo_cnt_next = '0;
            state_next   = WAIT_DIG;
          end
        end
      end
      WAIT_DIG: begin
        if (hr_rise) begin
          dig_out_next   = hc_digest;
          dig_valid_next = 1'b1;
          state_next     = DONE;
        end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end
      DONE: begin
        if (dig_ready) begin
          dig_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed bench for hash_msg_feeder with a stand-in hash core and a queue-based model
// of the message stream and the expected digest.
module tb_hash_msg_feeder;

  localparam int DEPTH       = 16;
  localparam int LEN_W       = 16;
  localparam int TIMEOUT_CYC = 1024;
  localparam logic [31:0] IV = 32'hB4D92C3F;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wr_valid = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_ready;
  logic             start = 1'b0;
  logic [LEN_W-1:0] msg_len = '0;
  logic             start_ready;
  logic [7:0]       hc_m;
  logic             hc_m_valid;
  logic [63:0]      hc_len;
  logic             hc_hash_ready;
  logic [31:0]      hc_digest;
  logic             dig_valid;
  logic             dig_ready = 1'b0;
  logic [31:0]      dig_out;
  logic             err_timeout;

  hash_msg_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .msg_len(msg_len), .start_ready(start_ready),
    .hc_m(hc_m), .hc_m_valid(hc_m_valid), .hc_len(hc_len),
    .hc_hash_ready(hc_hash_ready), .hc_digest(hc_digest),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_out(dig_out),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Stand-in core: digest = rotate-left-8 then xor each valid byte, seeded with IV.
  logic        core_hr = 1'b0;
  logic        force_hr = 1'b0;
  logic [31:0] core_dig = 32'h0;
  assign hc_hash_ready = force_hr | core_hr;
  assign hc_digest     = core_dig;

  int passed = 0;
  int total  = 0;

  // Model state
  logic [7:0]  host_q[$];
  logic [31:0] exp_h = IV;
  int          cur_len = 0;
  int          m_sent = 0;
  bit          msg_active = 1'b0;
  int          run = 0;
  int          max_run = 0;
  int          zero_pulses = 0;
  int          n_digests = 0;

  function automatic logic [31:0] hstep(input logic [31:0] h, input logic [7:0] b);
    return {h[23:0], h[31:24]} ^ {24'h0, b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic core_mock();
    int          cnt = 0;
    int          delay = 0;
    logic [31:0] h = IV;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cnt = 0; delay = 0; h = IV; core_hr = 1'b0;
      end else begin
        if (delay != 0) begin
          delay--;
          if (delay == 0) begin core_dig = h; core_hr = 1'b1; end
        end
        if (hc_m_valid) begin
          if (cnt == 0) begin h = IV; core_hr = 1'b0; end
          if (hc_len != 64'h0) h = hstep(h, hc_m);
          cnt++;
          if (hc_len == 64'h0 || 64'(cnt) == hc_len) begin cnt = 0; delay = 3; end
        end
      end
    end
  endtask

  // Outputs seen at a negedge reflect the previous posedge; inputs seen here are what
  // the next posedge will act on, so they update the model after the output checks.
  task automatic monitor();
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (!reset) begin
        host_q.delete(); msg_active = 1'b0; m_sent = 0; run = 0;
      end else begin
        if (hc_m_valid) begin
          run++;
          if (run > max_run) max_run = run;
          chk("hc_len", hc_len, 64'(cur_len));
          if (!msg_active) chk("spurious_valid", 64'(hc_m_valid), 64'h0);
          else if (cur_len == 0) begin
            chk("zero_byte", 64'(hc_m), 64'h0);
            zero_pulses++;
          end else if (host_q.size() == 0 || m_sent >= cur_len) begin
            chk("overrun", 64'(hc_m_valid), 64'h0);
          end else begin
            exp_b = host_q.pop_front();
            chk("hc_m", 64'(hc_m), 64'(exp_b));
            exp_h = hstep(exp_h, exp_b);
            m_sent++;
          end
        end else begin
          run = 0;
        end
        chk("wr_ready", 64'(wr_ready), 64'(host_q.size() != DEPTH));
        if (dig_valid) begin
          chk("dig_out_model", 64'(dig_out), 64'(exp_h));
          chk("dig_len", 64'(m_sent), 64'(cur_len));
        end
        if (wr_valid && wr_ready) host_q.push_back(wr_data);
        if (start && start_ready) begin
          cur_len = int'(msg_len); m_sent = 0; exp_h = IV; msg_active = 1'b1;
          run = 0; max_run = 0; zero_pulses = 0;
        end
        if (dig_valid && dig_ready) begin
          msg_active = 1'b0; n_digests++;
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit acc;
    wr_valid = 1'b1; wr_data = b;
    for (int i = 0; i < 200; i++) begin
      acc = wr_ready;
      tick(1);
      if (acc) break;
    end
    chk("push_accept", 64'(acc), 64'h1);
    wr_valid = 1'b0;
  endtask

  task automatic do_start(input int len);
    bit acc;
    start = 1'b1; msg_len = LEN_W'(len);
    for (int i = 0; i < 200; i++) begin
      acc = start_ready;
      tick(1);
      if (acc) break;
    end
    chk("start_accept", 64'(acc), 64'h1);
    start = 1'b0;
  endtask

  task automatic get_digest(output logic [31:0] d, output bit rdy_seen);
    rdy_seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (dig_valid) break;
      if (start_ready) rdy_seen = 1'b1;
      tick(1);
    end
    chk("dig_valid_wait", 64'(dig_valid), 64'h1);
    if (start_ready) rdy_seen = 1'b1;
    d = dig_out;
    dig_ready = 1'b1;
    tick(1);
    dig_ready = 1'b0;
    chk("idle_after_consume", 64'(start_ready), 64'h1);
  endtask

  logic [31:0] d;
  bit          rs;
  int          elapsed;
  int          ndig;

  initial begin
    fork
      core_mock();
      monitor();
    join_none

    // Reset state
    tick(3);
    chk("rst_hc_m_valid", 64'(hc_m_valid), 64'h0);
    chk("rst_hc_m", 64'(hc_m), 64'h0);
    chk("rst_hc_len", hc_len, 64'h0);
    chk("rst_dig_valid", 64'(dig_valid), 64'h0);
    chk("rst_dig_out", 64'(dig_out), 64'h0);
    chk("rst_err", 64'(err_timeout), 64'h0);
    chk("rst_start_ready", 64'(start_ready), 64'h1);
    chk("rst_wr_ready", 64'(wr_ready), 64'h1);
    reset = 1'b1;
    tick(2);

    // 1: empty message
    do_start(0);
    get_digest(d, rs);
    chk("t1_digest_iv", 64'(d), 64'(32'hB4D92C3F));
    chk("t1_one_pulse", 64'(zero_pulses), 64'h1);

    // 2: "abc"
    push_byte(8'h61); push_byte(8'h62); push_byte(8'h63);
    do_start(3);
    get_digest(d, rs);
    chk("t2_digest", 64'(d), 64'(32'h3FD5BB4F));
    chk("t2_burst3", 64'(max_run), 64'h3);
    chk("t2_start_ready_low", 64'(rs), 64'h0);

    // 3: gapped delivery from an empty FIFO
    do_start(4);
    for (int i = 1; i <= 4; i++) begin
      push_byte(8'(i));
      tick(2);
    end
    get_digest(d, rs);
    chk("t3_digest", 64'(d), 64'(32'hB5DB2F3B));
    chk("t3_gaps", 64'(max_run), 64'h1);

    // 4: full FIFO, then stream DEPTH+5 bytes while refilling
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i));
    chk("t4_full", 64'(wr_ready), 64'h0);
    do_start(DEPTH + 5);
    for (int i = DEPTH; i < DEPTH + 5; i++) push_byte(8'(8'h10 + i));
    get_digest(d, rs);
    chk("t4_sent_all", 64'(m_sent), 64'(DEPTH + 5));

    // 5: hash_ready stuck high -> timeout
    force_hr = 1'b1;
    ndig = n_digests;
    push_byte(8'h77);
    do_start(1);
    elapsed = 0;
    for (int i = 1; i <= 1200; i++) begin
      tick(1);
      elapsed = i;
      if (err_timeout) break;
    end
    chk("t5_err", 64'(err_timeout), 64'h1);
    chk("t5_elapsed_ok", 64'(elapsed >= TIMEOUT_CYC && elapsed <= TIMEOUT_CYC + 6), 64'h1);
    chk("t5_idle", 64'(start_ready), 64'h1);
    chk("t5_no_dig", 64'(dig_valid), 64'h0);
    chk("t5_no_capture", 64'(n_digests), 64'(ndig));
    force_hr = 1'b0;
    do_start(0);
    chk("t5_err_cleared", 64'(err_timeout), 64'h0);
    get_digest(d, rs);
    chk("t5_next_digest", 64'(d), 64'(IV));

    // 6: reset in the middle of SEND
    for (int i = 0; i < 8; i++) push_byte(8'(8'hA0 + i));
    do_start(8);
    for (int i = 0; i < 50; i++) begin
      if (m_sent >= 2) break;
      tick(1);
    end
    chk("t6_mid_send", 64'(m_sent >= 2 && m_sent < 8), 64'h1);
    reset = 1'b0;
    #1;
    chk("t6_valid_drop", 64'(hc_m_valid), 64'h0);
    chk("t6_len_clear", hc_len, 64'h0);
    tick(2);
    reset = 1'b1;
    tick(1);
    do_start(2);
    tick(5);
    chk("t6_fifo_empty", 64'(m_sent), 64'h0);
    push_byte(8'h5A); push_byte(8'h5B);
    get_digest(d, rs);
    chk("t6_digest", 64'(d), 64'(32'h2C3FEE82));

    tick(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
